// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one imem request outstanding, and buffers returned words for decode.
// Defining FETCH_PERF_EN adds the perf_fetched / perf_discarded counter outputs.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_b,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        stall,
    input  logic        halt,
    output logic [31:0] inst,
    output logic [31:0] inst_addr,
    output logic        inst_valid,
    output logic        fetch_halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_discarded
`endif
);

    localparam int unsigned PW = $clog2(BUF_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_C = BUF_DEPTH[CW:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD,
        S_HALTED
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_addr_q;
    logic          halt_q;
    logic [31:0]   fifo_addr_q [BUF_DEPTH];
    logic [31:0]   fifo_word_q [BUF_DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] count_q, count_d;

    logic          halt_now;
    logic          redir;
    logic          flush;
    logic          push;
    logic          pop;
    logic          issue;
    logic [CW:0]   occ_after;

    // Outputs to decode are bubbles whenever the FIFO is empty or the stage is halted.
    always_comb begin
        inst_valid   = (count_q != '0) && !halt_q;
        inst         = inst_valid ? fifo_word_q[rd_ptr_q] : '0;
        inst_addr    = inst_valid ? fifo_addr_q[rd_ptr_q] : '0;
        fetch_halted = (state_q == S_HALTED);
    end

    // Redirect and halt both flush, so they pre-empt any pop, push or issue this cycle.
    always_comb begin
        halt_now  = halt_q || halt;
        redir     = redirect && !halt_q;
        flush     = redir || halt_now;
        pop       = inst_valid && !stall;
        push      = imem_ack && (state_q == S_WAIT) && !flush;
        occ_after = {1'b0, count_q} + {{CW{1'b0}}, push} - {{CW{1'b0}}, pop};
        count_d   = occ_after[CW-1:0];
        issue     = rst_b && !flush
                    && ((state_q == S_IDLE) || ((state_q == S_WAIT) && imem_ack))
                    && (occ_after < DEPTH_C);
        imem_req  = issue;
        imem_addr = pc_q;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (redir) begin
            pc_d = redirect_target;
        end else if (issue) begin
            pc_d = pc_q + 32'd4;
        end

        unique case (state_q)
            S_IDLE: begin
                if (halt_now) begin
                    state_d = S_HALTED;
                end else if (issue) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (halt_now) begin
                    state_d = imem_ack ? S_HALTED : S_DISCARD;
                end else if (redir) begin
                    state_d = imem_ack ? S_IDLE : S_DISCARD;
                end else if (imem_ack) begin
                    state_d = issue ? S_WAIT : S_IDLE;
                end
            end
            S_DISCARD: begin
                if (imem_ack) begin
                    state_d = halt_now ? S_HALTED : S_IDLE;
                end
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
            halt_q     <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (issue) begin
                req_addr_q <= pc_q;
            end
            if (halt) begin
                halt_q <= 1'b1;
            end
            if (flush) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                count_q <= count_d;
            end
        end
    end

    // Storage carries no reset: entries are only observable through inst_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= req_addr_q;
            fifo_word_q[wr_ptr_q] <= imem_data;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_discarded_q;
    logic        drop;

    always_comb begin
        drop           = imem_ack && ((state_q == S_DISCARD) || ((state_q == S_WAIT) && redir));
        perf_fetched   = perf_fetched_q;
        perf_discarded = perf_discarded_q;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            perf_fetched_q   <= '0;
            perf_discarded_q <= '0;
        end else if (!halt_q) begin
            if (pop && !flush) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (drop) begin
                perf_discarded_q <= perf_discarded_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a variable-latency imem responder plus hand-computed expectations.
module tb_fetch_stage;

    logic        clk;
    logic        rst_b;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        stall;
    logic        halt;
    logic [31:0] inst;
    logic [31:0] inst_addr;
    logic        inst_valid;
    logic        fetch_halted;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_discarded;
`endif

    int          vecs = 0;
    int          errs = 0;

    bit          pend;
    int          cnt;
    int          lat;
    logic [31:0] paddr;

    fetch_stage #(
        .RESET_PC  (32'h0000_0400),
        .BUF_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_data       (imem_data),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .stall           (stall),
        .halt            (halt),
        .inst            (inst),
        .inst_addr       (inst_addr),
        .inst_valid      (inst_valid),
        .fetch_halted    (fetch_halted)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_discarded  (perf_discarded)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present this cycle's memory response, let the DUT settle, then capture any new request.
    task automatic drive();
        imem_ack  = 1'b0;
        imem_data = '0;
        if (pend) begin
            if (cnt == 0) begin
                imem_ack  = 1'b1;
                imem_data = dat(paddr);
                pend      = 1'b0;
            end else begin
                cnt--;
            end
        end
        #1;
        if (imem_req) begin
            pend  = 1'b1;
            cnt   = lat - 1;
            paddr = imem_addr;
        end
    endtask

    task automatic do_reset(input int l);
        rst_b     = 1'b0;
        pend      = 1'b0;
        imem_ack  = 1'b0;
        imem_data = '0;
        stall     = 1'b0;
        redirect  = 1'b0;
        halt      = 1'b0;
        lat       = l;
        tick();
        tick();
        rst_b = 1'b1;
    endtask

    initial begin
        rst_b           = 1'b0;
        stall           = 1'b0;
        redirect        = 1'b0;
        redirect_target = '0;
        halt            = 1'b0;
        imem_ack        = 1'b0;
        imem_data       = '0;
        lat             = 1;
        pend            = 1'b0;
        cnt             = 0;
        paddr           = '0;
        repeat (2) @(posedge clk);
        #1;

        chk1("rst_req", imem_req, 1'b0);
        chk1("rst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_addr", inst_addr, 32'h0);
        chk1("rst_halted", fetch_halted, 1'b0);

        // Streaming with 1-cycle memory
        rst_b = 1'b1;
        drive();
        chk1("s_req0", imem_req, 1'b1);
        chk("s_addr0", imem_addr, 32'h400);
        chk1("s_valid0", inst_valid, 1'b0);
        tick();
        drive();
        chk1("s_req1", imem_req, 1'b1);
        chk("s_addr1", imem_addr, 32'h404);
        chk1("s_valid1", inst_valid, 1'b0);
        tick();
        drive();
        chk("s_addr2", imem_addr, 32'h408);
        chk1("s_valid2", inst_valid, 1'b1);
        chk("s_iaddr2", inst_addr, 32'h400);
        chk("s_inst2", inst, dat(32'h400));
        tick();
        drive();
        chk("s_addr3", imem_addr, 32'h40C);
        chk("s_iaddr3", inst_addr, 32'h404);
        tick();

        // Stall fills the two-entry FIFO and holds the head
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive();
            chk1("st_req", imem_req, 1'b0);
            chk("st_head_addr", inst_addr, 32'h408);
            chk("st_head_inst", inst, dat(32'h408));
            tick();
        end
        stall = 1'b0;
        drive();
        chk("st_rel_addr0", imem_addr, 32'h410);
        chk("st_rel_iaddr0", inst_addr, 32'h408);
        tick();
        drive();
        chk("st_rel_addr1", imem_addr, 32'h414);
        chk("st_rel_iaddr1", inst_addr, 32'h40C);
        tick();
        drive();
        chk("st_rel_iaddr2", inst_addr, 32'h410);
        chk("st_rel_inst2", inst, dat(32'h410));
        tick();

        // Redirect while a 3-cycle request is outstanding
        do_reset(3);
        drive();
        chk("r3_addr0", imem_addr, 32'h400);
        tick();
        drive();
        chk1("r3_noreq", imem_req, 1'b0);
        tick();
        drive();
        tick();
        drive();
        chk("r3_addr1", imem_addr, 32'h404);
        tick();
        drive();
        chk("r3_iaddr0", inst_addr, 32'h400);
        tick();
        drive();
        tick();
        drive();
        chk("r3_addr2", imem_addr, 32'h408);
        tick();
        redirect        = 1'b1;
        redirect_target = 32'h0000_1000;
        drive();
        chk1("r3_redir_req", imem_req, 1'b0);
        chk("r3_redir_head", inst_addr, 32'h404);
        tick();
        redirect = 1'b0;
        drive();
        chk1("r3_flushed", inst_valid, 1'b0);
        tick();
        drive();
        chk1("r3_drop_req", imem_req, 1'b0);
        tick();
        drive();
        chk1("r3_tgt_req", imem_req, 1'b1);
        chk("r3_tgt_addr", imem_addr, 32'h1000);
        chk1("r3_tgt_valid", inst_valid, 1'b0);
        tick();
        drive();
        tick();
        drive();
        tick();
        drive();
        chk("r3_next_addr", imem_addr, 32'h1004);
        tick();
        drive();
        chk("r3_first_iaddr", inst_addr, 32'h1000);
        chk("r3_first_inst", inst, dat(32'h1000));
`ifdef FETCH_PERF_EN
        chk("r3_perf_disc", perf_discarded, 32'd1);
`endif
        tick();

        // Redirect coinciding with an ack and a pop
        do_reset(1);
        drive();
        tick();
        drive();
        chk("ra_addr1", imem_addr, 32'h404);
        tick();
        redirect        = 1'b1;
        redirect_target = 32'h0000_2000;
        drive();
        chk1("ra_req", imem_req, 1'b0);
        chk("ra_head", inst_addr, 32'h400);
        tick();
        redirect = 1'b0;
        drive();
        chk1("ra_empty", inst_valid, 1'b0);
        chk("ra_tgt_addr", imem_addr, 32'h2000);
        chk1("ra_tgt_req", imem_req, 1'b1);
`ifdef FETCH_PERF_EN
        chk("ra_perf_disc", perf_discarded, 32'd1);
`endif
        tick();
        drive();
        chk1("ra_still_empty", inst_valid, 1'b0);
        tick();
        drive();
        chk("ra_first_iaddr", inst_addr, 32'h2000);
        chk("ra_first_inst", inst, dat(32'h2000));
        tick();

        // Halt with a 2-cycle request outstanding
        do_reset(2);
        drive();
        tick();
        drive();
        tick();
        drive();
        chk("h_addr1", imem_addr, 32'h404);
        tick();
        stall = 1'b1;
        halt  = 1'b1;
        drive();
        chk1("h_req", imem_req, 1'b0);
        chk("h_head", inst_addr, 32'h400);
        tick();
        halt = 1'b0;
        drive();
        chk1("h_valid", inst_valid, 1'b0);
        chk("h_inst", inst, 32'h0);
        chk1("h_req_ack", imem_req, 1'b0);
        chk1("h_not_yet", fetch_halted, 1'b0);
        tick();
        redirect        = 1'b1;
        redirect_target = 32'h0000_3000;
        drive();
        chk1("h_halted", fetch_halted, 1'b1);
        chk1("h_redir_req", imem_req, 1'b0);
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive();
            chk1("h_stay_req", imem_req, 1'b0);
            chk1("h_stay_halted", fetch_halted, 1'b1);
            chk1("h_stay_valid", inst_valid, 1'b0);
            tick();
        end

        // Reset during WAIT, stale ack right after release
        do_reset(3);
        drive();
        tick();
        drive();
        #1;
        rst_b = 1'b0;
        #1;
        chk1("sr_req", imem_req, 1'b0);
        chk1("sr_valid", inst_valid, 1'b0);
        tick();
        tick();
        lat       = 1;
        pend      = 1'b0;
        rst_b     = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 32'hBAD0_BAD0;
        #1;
        chk1("sr_restart_req", imem_req, 1'b1);
        chk("sr_restart_addr", imem_addr, 32'h400);
        chk1("sr_restart_valid", inst_valid, 1'b0);
        if (imem_req) begin
            pend  = 1'b1;
            cnt   = lat - 1;
            paddr = imem_addr;
        end
        tick();
        drive();
        chk1("sr_stale_dropped", inst_valid, 1'b0);
        chk("sr_addr1", imem_addr, 32'h404);
        tick();
        drive();
        chk("sr_iaddr", inst_addr, 32'h400);
        chk("sr_inst", inst, dat(32'h400));
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
